fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of decode and immediate sign-extension.
- Owns the PC and issues word requests to instruction memory over a req/ack handshake.
- Buffers fetched {pc, instr} pairs in a small FIFO and presents them to decode over a valid/ready handshake.
- Consumes the sign-extended branch offset produced downstream to compute redirect targets.

---
 rtl/fetch_unit.sv | 188 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches words over imem req/ack, buffers them for decode.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets (sticky fetch_fault).
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_base,
    input  logic [31:0] redirect_imm,
    output logic        fetch_fault
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   addr_q, addr_d;
    logic          req_q, req_d;
    logic          fault_q, fault_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   head_pc_q, head_pc_d;
    logic [31:0]   head_instr_q, head_instr_d;

    logic [31:0]   mem_pc_q    [FIFO_DEPTH];
    logic [31:0]   mem_instr_q [FIFO_DEPTH];

    logic [31:0]   target;
    logic [31:0]   tgt_pc;
    logic          fault_set;
    logic          pop;
    logic          push;
    logic          room;
    logic          issue_ok;

    always_comb begin
        target = redirect_base + (redirect_imm << 1);
`ifdef FETCH_MISALIGN_TRAP_EN
        tgt_pc    = target;
        fault_set = (target[1:0] != 2'b00);
`else
        tgt_pc    = target & 32'hFFFF_FFFC;
        fault_set = 1'b0;
`endif
    end

    // Data returned for a request that a redirect has overtaken is never pushed.
    assign pop  = (cnt_q != '0) && instr_ready;
    assign push = (state_q == WAIT) && imem_ack && !redirect;

    always_comb begin
        if (redirect) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            rd_d  = rd_q + AW'(pop);
            wr_d  = wr_q + AW'(push);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        head_pc_d    = head_pc_q;
        head_instr_d = head_instr_q;
        if (!redirect && (cnt_d != '0)) begin
            if (push && (wr_q == rd_d)) begin
                head_pc_d    = addr_q;
                head_instr_d = imem_rdata;
            end else begin
                head_pc_d    = mem_pc_q[rd_d];
                head_instr_d = mem_instr_q[rd_d];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        req_d    = req_q;
        fault_d  = fault_q | (redirect & fault_set);
        room     = (cnt_d < DEPTH_C);
        issue_ok = room && !fault_d;
        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    pc_d = tgt_pc;
                end else if (issue_ok) begin
                    state_d = WAIT;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_d = tgt_pc;
                    if (imem_ack) begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end else begin
                        state_d = DROP;
                    end
                end else if (imem_ack) begin
                    pc_d = pc_q + 32'd4;
                    if (issue_ok) begin
                        addr_d = pc_q + 32'd4;
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            DROP: begin
                if (redirect) begin
                    pc_d = tgt_pc;
                end
                if (imem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            req_q        <= 1'b0;
            fault_q      <= 1'b0;
            rd_q         <= '0;
            wr_q         <= '0;
            cnt_q        <= '0;
            head_pc_q    <= '0;
            head_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            req_q        <= req_d;
            fault_q      <= fault_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            cnt_q        <= cnt_d;
            head_pc_q    <= head_pc_d;
            head_instr_q <= head_instr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem_pc_q[wr_q]    <= addr_q;
            mem_instr_q[wr_q] <= imem_rdata;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign instr_valid = (cnt_q != '0);
    assign instr       = head_instr_q;
    assign instr_pc    = head_pc_q;
    assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and random stimulus against a queue-based fetch model.
// Build with FETCH_MISALIGN_TRAP_EN to check the trapping variant.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_base;
    logic [31:0] redirect_imm;
    logic        fetch_fault;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC  (RESET_PC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_ready  (instr_ready),
        .redirect     (redirect),
        .redirect_base(redirect_base),
        .redirect_imm (redirect_imm),
        .fetch_fault  (fetch_fault)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] iss_q[$];
    logic [31:0] pops_q[$];
    logic [31:0] exp_pc;
    logic [31:0] out_addr;
    bit          outst;
    bit          stale;
    bit          m_fault;
    int          gap;
    int          acks;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_iss(input string tag, input int idx,
                           input logic [31:0] exp);
        chk({tag, "_n"}, iss_q.size() > idx, 1);
        if (iss_q.size() > idx) chk(tag, iss_q[idx], exp);
    endtask

    task automatic model_reset();
        mq.delete();
        iss_q.delete();
        pops_q.delete();
        exp_pc  = RESET_PC;
        outst   = 0;
        stale   = 0;
        m_fault = 0;
        gap     = 0;
        acks    = 0;
    endtask

    task automatic set_in(input logic ack, input logic rdy, input logic rd,
                          input logic [31:0] b, input logic [31:0] i);
        imem_ack      = ack;
        imem_rdata    = $urandom;
        instr_ready   = rdy;
        redirect      = rd;
        redirect_base = b;
        redirect_imm  = i;
    endtask

    task automatic cyc_begin();
        bit may;
        @(negedge clk);
        may = (mq.size() < DEPTH) && !m_fault;
        chk("fault", fetch_fault, m_fault);
        chk("valid", instr_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("instr", instr, mq[0].ins);
            chk("instr_pc", instr_pc, mq[0].pc);
        end
        if (outst) begin
            chk("req_hold", imem_req, 1);
            chk("addr_hold", imem_addr, out_addr);
            gap = 0;
        end else begin
            if (!may) chk("req_idle", imem_req, 0);
            if (imem_req) begin
                if (may) chk("issue_addr", imem_addr, exp_pc);
                outst    = 1;
                stale    = 0;
                out_addr = imem_addr;
                iss_q.push_back(imem_addr);
                gap = 0;
            end else if (may) begin
                gap++;
                if (gap == 3) chk("live_gap", gap, 2);
            end else begin
                gap = 0;
            end
        end
    endtask

    task automatic cyc_end();
        logic [31:0] t;
        ent_t        e;
        if (mq.size() != 0 && instr_ready) begin
            pops_q.push_back(mq[0].pc);
            void'(mq.pop_front());
        end
        if (imem_ack && outst) begin
            acks++;
            outst = 0;
            if (!redirect && !stale) begin
                e.pc  = out_addr;
                e.ins = imem_rdata;
                mq.push_back(e);
                exp_pc = out_addr + 4;
            end
        end
        if (redirect) begin
            mq.delete();
            t = redirect_base + redirect_imm * 2;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (t % 4 != 0) m_fault = 1;
            exp_pc = t;
`else
            exp_pc = t - (t % 4);
`endif
            if (outst) stale = 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        set_in(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_req", imem_req, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_fault", fetch_fault, 0);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic run_to_addr(input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] i, input int n);
        bit done = 0;
        for (int k = 0; k < n; k++) begin
            cyc_begin();
            if (!done && imem_req && imem_addr == a) begin
                set_in(1, 1, 1, b, i);
                done = 1;
            end else begin
                set_in(imem_req, 1, 0, 0, 0);
            end
            cyc_end();
        end
        chk("redir_hit", done, 1);
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 0, 0, 0, 0);
        model_reset();

        do_reset();
        for (int k = 0; k < 12; k++) begin
            cyc_begin();
            set_in(imem_req, 1, 0, 0, 0);
            cyc_end();
        end
        chk_iss("seq0", 0, 32'h0);
        chk_iss("seq1", 1, 32'h4);
        chk_iss("seq2", 2, 32'h8);

        do_reset();
        for (int k = 0; k < 10; k++) begin
            cyc_begin();
            set_in(imem_req, 0, 0, 0, 0);
            cyc_end();
        end
        chk("full_acks", acks, 2);
        chk("full_noreq", imem_req, 0);
        for (int k = 0; k < 6; k++) begin
            cyc_begin();
            set_in(imem_req, 1, 0, 0, 0);
            cyc_end();
        end
        chk("pop0", pops_q.size() > 1 ? pops_q[0] : 32'hDEAD_BEEF, 32'h0);
        chk("pop1", pops_q.size() > 1 ? pops_q[1] : 32'hDEAD_BEEF, 32'h4);
        chk_iss("resume", 2, 32'h8);

        do_reset();
        begin
            bit done = 0;
            int hold = 0;
            for (int k = 0; k < 40; k++) begin
                cyc_begin();
                if (!done && imem_req && imem_addr == 32'h10) begin
                    set_in(0, 1, 1, 32'h20, 32'hFFFF_FFFC);
                    done = 1;
                    hold = 3;
                end else if (hold > 0) begin
                    hold--;
                    set_in(0, 1, 0, 0, 0);
                end else begin
                    set_in(imem_req, 1, 0, 0, 0);
                end
                cyc_end();
            end
        end
        chk_iss("drop_old", 4, 32'h10);
        chk_iss("drop_tgt", 5, 32'h18);

        do_reset();
        begin
            bit done = 0;
            for (int k = 0; k < 12; k++) begin
                cyc_begin();
                if (done) begin
                    chk("flush_pop", instr_valid, 0);
                    done = 0;
                end
                if (k < 6 && imem_req && imem_addr == 32'h4 && mq.size() == 1) begin
                    set_in(1, 1, 1, 32'h40, 32'h8);
                    done = 1;
                end else begin
                    set_in(imem_req, k >= 6, 0, 0, 0);
                end
                cyc_end();
            end
        end
        chk_iss("ackredir", 2, 32'h50);

        do_reset();
        run_to_addr(32'h8, 32'hFFFF_FFFC, 32'h2, 12);
        chk_iss("wrap", 3, 32'h0);

        do_reset();
        run_to_addr(32'h8, 32'h100, 32'h1, 14);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_fault", fetch_fault, 1);
        chk("mis_noreq", imem_req, 0);
        chk("mis_iss", iss_q.size(), 3);
`else
        chk("mis_fault", fetch_fault, 0);
        chk_iss("mis_align", 3, 32'h100);
`endif

        do_reset();
        for (int k = 0; k < 3000; k++) begin
            logic [31:0] b;
            logic [31:0] i;
            if (k % 700 == 699) do_reset();
            cyc_begin();
            b = $urandom;
            i = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 64) : $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            b = b & 32'hFFFF_FFFC;
            i = i & 32'hFFFF_FFFE;
`endif
            set_in(imem_req && ($urandom_range(0, 1) == 1),
                   $urandom_range(0, 9) < 6,
                   $urandom_range(0, 19) == 0, b, i);
            cyc_end();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
